// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR tap sequencer.
// Holds the FSM state encoding and the power-on coefficient profile.
package fir_pkg;

  localparam int FIR_N  = 4;
  localparam int FIR_DW = 16;
  localparam int FIR_AW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  function automatic logic [31:0] default_coef(input int k);
    return 32'(k + 1);
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample, result and coefficient-write signals of the FIR tap sequencer.
// The slave modport is the filter's view; the master modport is the environment's view.
interface fir_if
  import fir_pkg::*;
#(
  parameter int N  = FIR_N,
  parameter int DW = FIR_DW,
  parameter int AW = FIR_AW
);
  localparam int TW = $clog2(N);

  logic signed [DW-1:0] xn;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] yn;
  logic                 out_valid;
  logic                 out_ready;
  logic                 coef_we;
  logic [TW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 coef_err;
  logic                 busy;

  modport slave (
    input  xn, in_valid, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, yn, out_valid, coef_err, busy
  );

  modport master (
    output xn, in_valid, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, yn, out_valid, coef_err, busy
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Run-time writable coefficient register file: one write port, one async read port.
// Comes out of reset holding the default profile b[k] = k+1.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N  = FIR_N,
  parameter int DW = FIR_DW,
  localparam int TW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [TW-1:0]        addr_i,
  input  logic signed [DW-1:0] data_i,
  input  logic [TW-1:0]        rd_addr_i,
  output logic signed [DW-1:0] rd_data_o
);

  logic signed [DW-1:0] mem_q [N];

  // Coefficient storage with default reload on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= DW'(default_coef(k));
      end
    end else if (we_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one signed multiplier walks N taps per sample over a
// circular delay buffer, y[n] = sum_k b[k]*x[n-k], results handed off over valid/ready.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int N  = FIR_N,
  parameter int DW = FIR_DW,
  parameter int AW = FIR_AW
) (
  input  logic   clk,
  input  logic   reset,
  fir_if.slave   bus
);

  localparam int TW = $clog2(N);
  localparam logic [TW:0]   N_W    = (TW+1)'(N);
  localparam logic [TW-1:0] LAST_W = TW'(N - 1);

  fir_state_e           state_q;
  logic [TW-1:0]        tap_q;
  logic [TW-1:0]        wr_ptr_q;
  logic [TW-1:0]        newest_q;
  logic signed [DW-1:0] dly_q [N];
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] yn_q;
  logic                 out_valid_q;
  logic                 coef_err_q;
  logic                 busy_q;
  logic                 in_ready_q;

  logic                   addr_ok;
  logic                   coef_wr_ok;
  logic [TW-1:0]          rd_idx;
  logic signed [DW-1:0]   coef_rd;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_d;

  // Non-power-of-two tap counts leave address codes that name no coefficient
  if ((1 << TW) == N) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (bus.coef_addr < TW'(N));
  end

  assign coef_wr_ok = bus.coef_we & (state_q == IDLE) & addr_ok;

  fir_coef_bank #(.N(N), .DW(DW)) u_coef_bank (
    .clk       (clk),
    .reset     (reset),
    .we_i      (coef_wr_ok),
    .addr_i    (bus.coef_addr),
    .data_i    (bus.coef_data),
    .rd_addr_i (tap_q),
    .rd_data_o (coef_rd)
  );

  // History index (newest - tap) mod N
  always_comb begin
    if (newest_q >= tap_q) begin
      rd_idx = newest_q - tap_q;
    end else begin
      rd_idx = TW'({1'b0, newest_q} + N_W - {1'b0, tap_q});
    end
  end

  // Single multiply-accumulate step; the sized cast sign-extends the product
  always_comb begin
    prod  = coef_rd * dly_q[rd_idx];
    acc_d = acc_q + AW'(prod);
  end

  // Control FSM, delay buffer, accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      for (int i = 0; i < N; i++) begin
        dly_q[i] <= '0;
      end
      acc_q       <= '0;
      yn_q        <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      coef_err_q <= bus.coef_we & ~coef_wr_ok;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dly_q[wr_ptr_q] <= bus.xn;
            newest_q        <= wr_ptr_q;
            wr_ptr_q        <= (wr_ptr_q == LAST_W) ? '0 : wr_ptr_q + TW'(1);
            acc_q           <= '0;
            tap_q           <= '0;
            busy_q          <= 1'b1;
            in_ready_q      <= 1'b0;
            state_q         <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (tap_q == LAST_W) begin
            state_q <= DONE;
          end else begin
            tap_q <= tap_q + TW'(1);
          end
        end
        DONE: begin
          // Result is published one cycle after the last tap, then held for the consumer
          if (!out_valid_q) begin
            yn_q        <= acc_q;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.yn        = yn_q;
  assign bus.out_valid = out_valid_q;
  assign bus.coef_err  = coef_err_q;
  assign bus.busy      = busy_q;

endmodule
